// File: rtl/mux_arb_pkg.sv
// Shared types, constants and the round-robin search used by the 4-way arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ          = 4;
  localparam int unsigned MAX_HOLD_DEFAULT = 8;

  typedef enum logic [0:0] {
    StIdle,
    StServe
  } state_e;

  // First set bit of req at or above ptr, wrapping 3 -> 0. Returns ptr when req is empty.
  function automatic logic [1:0] rr_next(input logic [NUM_REQ-1:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_next = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mux_arbiter_4_if.sv
// Request/data/grant bundle between the requesters and the arbitrated mux.
interface mux_arbiter_4_if #(
  parameter int unsigned BITS = 4
);
  import mux_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [BITS-1:0]    d0;
  logic [BITS-1:0]    d1;
  logic [BITS-1:0]    d2;
  logic [BITS-1:0]    d3;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         sel;
  logic [BITS-1:0]    data_out;
  logic               data_valid;

  modport master (
    output req, d0, d1, d2, d3,
    input  grant, sel, data_out, data_valid
  );

  modport slave (
    input  req, d0, d1, d2, d3,
    output grant, sel, data_out, data_valid
  );

endinterface

// File: rtl/mux_4x1_n.sv
// Plain 4:1 multiplexer of BITS-wide channels.
module mux_4x1_n #(
  parameter int unsigned BITS = 4
) (
  input  logic [1:0]      SEL,
  input  logic [BITS-1:0] d0_i,
  input  logic [BITS-1:0] d1_i,
  input  logic [BITS-1:0] d2_i,
  input  logic [BITS-1:0] d3_i,
  output logic [BITS-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (SEL)
      2'd0: y_o = d0_i;
      2'd1: y_o = d1_i;
      2'd2: y_o = d2_i;
      2'd3: y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/mux_arbiter_4.sv
// Round-robin 4-way arbiter with hold timeout, steering a shared 4:1 data mux.
module mux_arbiter_4
  import mux_arb_pkg::*;
#(
  parameter int unsigned BITS     = 4,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic            clock,
  input  logic            reset_n,
  mux_arbiter_4_if.slave  bus
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [7:0]         hold_q, hold_d;

  logic [NUM_REQ-1:0] pool;
  logic [1:0]         nxt;
  logic               take;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    take    = 1'b0;
    // Outside IDLE the owner never competes: on release its bit is low anyway,
    // on timeout it must yield to anyone else.
    pool    = (state_q == StIdle) ? bus.req : (bus.req & ~grant_q);
    nxt     = rr_next(pool, ptr_q);

    unique case (state_q)
      StIdle: begin
        if (|pool) take = 1'b1;
      end
      StServe: begin
        if (!bus.req[sel_q]) begin
          if (|pool) begin
            take = 1'b1;
          end else begin
            state_d = StIdle;
            grant_d = '0;
            hold_d  = '0;
          end
        end else if (hold_q < HoldLast) begin
          hold_d = hold_q + 8'd1;
        end else if (|pool) begin
          take = 1'b1;
        end else begin
          hold_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      state_d = StServe;
      grant_d = NUM_REQ'(1) << nxt;
      sel_d   = nxt;
      ptr_d   = nxt + 2'd1;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.sel        = sel_q;
  assign bus.data_valid = |grant_q;

  mux_4x1_n #(
    .BITS (BITS)
  ) u_mux (
    .SEL  (sel_q),
    .d0_i (bus.d0),
    .d1_i (bus.d1),
    .d2_i (bus.d2),
    .d3_i (bus.d3),
    .y_o  (bus.data_out)
  );

endmodule
